npc_imem_responder: RTL and testbench

//   Memory-side responder for instruction fetch: the other end of the fetch interface driven by my_IFU.

---
 rtl/npc_imem_responder_if.sv | 31 +++
 rtl/npc_imem_responder.sv | 134 +++++++++++++
 tb/tb_npc_imem_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_imem_responder_if.sv
// Fetch-side bus between the core's fetch unit (master) and the instruction
// memory responder (slave): one request channel, one response channel.
interface npc_imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_err
  );
endinterface

// File: rtl/npc_imem_responder.sv
// Instruction memory responder: accepts one fetch at a time, waits a fixed
// latency, then returns the addressed word (or an error) from a preloadable array.
module npc_imem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  npc_imem_responder_if.slave            bus,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  logic [31:0]                    ld_data,
  output logic                           busy
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // BASE_ADDR is word aligned, so the word offset is a 62-bit subtraction of the
  // upper address bits; a wrapped offset is caught by the below-base test.
  function automatic logic fetch_bad(input logic [63:0] addr, input logic beyond_depth);
    fetch_bad = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || beyond_depth;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic [63:0]       addr_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_instr_r;
  logic              rsp_err_r;
  logic              busy_r;
  logic              req_ready_s;
  logic              accept_s;
  logic              enter_resp_s;
  logic              rsp_done_s;
  logic [61:0]       word_off_s;
  logic [IDX_W-1:0]  idx_s;
  logic              fetch_err_s;
  logic [31:0]       mem_r [DEPTH_WORDS];

  assign req_ready_s = (state_r == ST_IDLE) && rst;
  assign accept_s    = bus.req_valid && req_ready_s;
  assign rsp_done_s  = rsp_valid_r && bus.rsp_ready;
  assign word_off_s  = addr_r[63:2] - BASE_ADDR[63:2];
  assign idx_s       = word_off_s[IDX_W-1:0];
  assign fetch_err_s = fetch_bad(addr_r, |word_off_s[61:IDX_W]);

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_instr = rsp_instr_r;
  assign bus.rsp_err   = rsp_err_r;
  assign busy          = busy_r;

  // Next-state decode; the wait counter spans LATENCY+1 cycles after the accept.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s  = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, captured address and registered response; the array read samples
  // the old word when a preload hits the same index on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= 64'h0;
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= 32'h0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (accept_s) begin
        addr_r <= bus.req_addr;
      end
      if (enter_resp_s) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= fetch_err_s;
        rsp_instr_r <= fetch_err_s ? 32'h0 : mem_r[idx_s];
      end else if (rsp_done_s) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  // Preload port: writes land on any edge regardless of state or reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_r[ld_idx] <= ld_data;
    end
  end

endmodule

// File: tb/tb_npc_imem_responder.sv
// Self-checking bench: a LATENCY=2 instance and a LATENCY=0 instance checked
// against a behavioural fetch model built from the address/latency rules.
module tb_npc_imem_responder;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int D2 = 1024;
  localparam int D0 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  npc_imem_responder_if bus2();
  npc_imem_responder_if bus0();

  logic        ld_en2 = 1'b0;
  logic [9:0]  ld_idx2 = 10'd0;
  logic [31:0] ld_data2 = 32'h0;
  logic        busy2;
  logic        ld_en0 = 1'b0;
  logic [3:0]  ld_idx0 = 4'd0;
  logic [31:0] ld_data0 = 32'h0;
  logic        busy0;

  logic [31:0] ref2 [D2];
  logic [31:0] ref0 [D0];

  npc_imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D2), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .ld_en(ld_en2), .ld_idx(ld_idx2), .ld_data(ld_data2), .busy(busy2)
  );

  npc_imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D0), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .ld_en(ld_en0), .ld_idx(ld_idx0), .ld_data(ld_data0), .busy(busy0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: error if misaligned, below base or beyond the array, else stored word.
  function automatic void model2(input logic [63:0] a, output logic [31:0] w, output logic e);
    logic [63:0] off;
    w = 32'h0;
    e = 1'b1;
    if (a[1:0] == 2'b00 && a >= BASE) begin
      off = (a - BASE) / 64'd4;
      if (off < 64'(D2)) begin
        w = ref2[int'(off)];
        e = 1'b0;
      end
    end
  endfunction

  function automatic void model0(input logic [63:0] a, output logic [31:0] w, output logic e);
    logic [63:0] off;
    w = 32'h0;
    e = 1'b1;
    if (a[1:0] == 2'b00 && a >= BASE) begin
      off = (a - BASE) / 64'd4;
      if (off < 64'(D0)) begin
        w = ref0[int'(off)];
        e = 1'b0;
      end
    end
  endfunction

  task automatic load2(input int idx, input logic [31:0] d);
    ld_en2 = 1'b1; ld_idx2 = 10'(idx); ld_data2 = d;
    @(posedge clk); #1;
    ld_en2 = 1'b0;
    ref2[idx] = d;
  endtask

  task automatic load0(input int idx, input logic [31:0] d);
    ld_en0 = 1'b1; ld_idx0 = 4'(idx); ld_data0 = d;
    @(posedge clk); #1;
    ld_en0 = 1'b0;
    ref0[idx] = d;
  endtask

  // Present one request in IDLE; returns #1 after the accepting edge.
  task automatic issue2(input logic [63:0] a);
    bus2.req_valid = 1'b1; bus2.req_addr = a;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0; bus2.req_addr = {$urandom, $urandom};
  endtask

  // Edges counted from the accept edge until rsp_valid is observed (bounded).
  task automatic wait_rsp2(output int lat);
    lat = 0;
    while (!bus2.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake2;
    bus2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus2.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, busy2, bus2.rsp_instr} !== 36'h0)
      $display("FAIL reset_outputs: got %h expected 0",
               {bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, busy2, bus2.rsp_instr});
    else n_pass++;
    n_checks++;
    if ({bus0.req_ready, bus0.rsp_valid, busy0} !== 3'b000)
      $display("FAIL reset_outputs_lat0: got %b expected 000", {bus0.req_ready, bus0.rsp_valid, busy0});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus2.req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", bus2.req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_preload;
    for (int i = 0; i < D2; i++) load2(i, $urandom);
    for (int i = 0; i < D0; i++) load0(i, $urandom);
  endtask

  task automatic test_basic_fetch;
    int lat;
    load2(0, 32'h0010_0093);
    issue2(BASE);
    n_checks++;
    if (busy2 !== 1'b1 || bus2.req_ready !== 1'b0)
      $display("FAIL busy_after_accept: got busy=%b ready=%b expected 1/0", busy2, bus2.req_ready);
    else n_pass++;
    wait_rsp2(lat);
    n_checks++;
    if (lat !== 3) $display("FAIL basic_latency: got %0d edges expected 3", lat);
    else n_pass++;
    n_checks++;
    if ({bus2.rsp_err, bus2.rsp_instr} !== {1'b0, 32'h0010_0093})
      $display("FAIL basic_word: got err=%b instr=%h expected 0/00100093", bus2.rsp_err, bus2.rsp_instr);
    else n_pass++;
    handshake2;
    n_checks++;
    if ({bus2.rsp_valid, busy2, bus2.req_ready, bus2.rsp_instr} !== {3'b001, 32'h0010_0093})
      $display("FAIL basic_return_idle: got valid=%b busy=%b ready=%b instr=%h expected 0/0/1/00100093",
               bus2.rsp_valid, busy2, bus2.req_ready, bus2.rsp_instr);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [31:0] w, wb;
    logic e, eb;
    logic [63:0] next_a;
    model2(BASE + 64'd20, w, e);
    next_a = BASE + 64'd4 * 64'($urandom_range(0, D2 - 1));
    model2(next_a, wb, eb);
    issue2(BASE + 64'd20);
    wait_rsp2(lat);
    bus2.req_valid = 1'b1; bus2.req_addr = next_a;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus2.rsp_valid, bus2.req_ready, bus2.rsp_err, bus2.rsp_instr} !== {2'b10, e, w})
        $display("FAIL hold_stable[%0d]: got valid=%b ready=%b err=%b instr=%h expected 1/0/%b/%h",
                 k, bus2.rsp_valid, bus2.req_ready, bus2.rsp_err, bus2.rsp_instr, e, w);
      else n_pass++;
    end
    handshake2;
    n_checks++;
    if (bus2.req_ready !== 1'b1 || busy2 !== 1'b0)
      $display("FAIL hold_release: got ready=%b busy=%b expected 1/0", bus2.req_ready, busy2);
    else n_pass++;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    wait_rsp2(lat);
    n_checks++;
    if (lat !== 3 || {bus2.rsp_err, bus2.rsp_instr} !== {eb, wb})
      $display("FAIL hold_next_fetch: got lat=%0d err=%b instr=%h expected 3/%b/%h",
               lat, bus2.rsp_err, bus2.rsp_instr, eb, wb);
    else n_pass++;
    handshake2;
  endtask

  task automatic test_errors;
    logic [63:0] bad [6];
    int lat;
    bad[0] = BASE + 64'd2;
    bad[1] = 64'h0000_0000_7FFF_FFFC;
    bad[2] = BASE + 64'd4 * 64'(D2);
    bad[3] = BASE + 64'd1;
    bad[4] = 64'h0;
    bad[5] = 64'hFFFF_FFFF_FFFF_FFFC;
    for (int i = 0; i < 6; i++) begin
      issue2(bad[i]);
      wait_rsp2(lat);
      n_checks++;
      if (lat !== 3 || bus2.rsp_err !== 1'b1 || bus2.rsp_instr !== 32'h0)
        $display("FAIL error_fetch[%h]: got lat=%0d err=%b instr=%h expected 3/1/00000000",
                 bad[i], lat, bus2.rsp_err, bus2.rsp_instr);
      else n_pass++;
      handshake2;
    end
  endtask

  task automatic test_last_word;
    int lat;
    load2(D2 - 1, 32'hDEAD_BEEF);
    issue2(BASE + 64'd4 * 64'(D2 - 1));
    wait_rsp2(lat);
    n_checks++;
    if (lat !== 3 || {bus2.rsp_err, bus2.rsp_instr} !== {1'b0, 32'hDEAD_BEEF})
      $display("FAIL last_word: got lat=%0d err=%b instr=%h expected 3/0/deadbeef",
               lat, bus2.rsp_err, bus2.rsp_instr);
    else n_pass++;
    handshake2;
  endtask

  task automatic test_random;
    int lat;
    logic [63:0] a;
    logic [31:0] w;
    logic e;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 64'd4 * 64'($urandom_range(0, D2 - 1));
        3:       a = BASE + 64'd4 * 64'($urandom_range(0, D2 - 1)) + 64'($urandom_range(1, 3));
        4:       a = BASE + 64'd4 * 64'(D2) + 64'd4 * 64'($urandom_range(0, 1000));
        default: a = BASE - 64'd4 * 64'($urandom_range(1, 1000));
      endcase
      model2(a, w, e);
      issue2(a);
      wait_rsp2(lat);
      n_checks++;
      if (lat !== 3 || {bus2.rsp_err, bus2.rsp_instr} !== {e, w})
        $display("FAIL random_fetch[%h]: got lat=%0d err=%b instr=%h expected 3/%b/%h",
                 a, lat, bus2.rsp_err, bus2.rsp_instr, e, w);
      else n_pass++;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      handshake2;
    end
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    logic seen;
    issue2(BASE);
    wait_rsp2(lat);
    handshake2;
    issue2(BASE + 64'd4 * 64'd7);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, busy2, bus2.rsp_instr} !== 36'h0)
      $display("FAIL reset_mid_wait: got %h expected 0",
               {bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, busy2, bus2.rsp_instr});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus2.rsp_valid === 1'b1 || busy2 === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL no_rsp_after_reset: got activity=%b expected 0", seen);
    else n_pass++;
    issue2(BASE + 64'd4 * 64'd9);
    wait_rsp2(lat);
    n_checks++;
    if (lat !== 3 || {bus2.rsp_err, bus2.rsp_instr} !== {1'b0, ref2[9]})
      $display("FAIL fetch_after_reset: got lat=%0d err=%b instr=%h expected 3/0/%h",
               lat, bus2.rsp_err, bus2.rsp_instr, ref2[9]);
    else n_pass++;
    handshake2;
  endtask

  task automatic test_lat0_back_to_back;
    logic [63:0] a;
    logic [31:0] w, nw;
    logic e, rbw, prev_rbw;
    int idx, prev_idx, k, acc_cyc, prev_acc;
    prev_rbw = 1'b0; prev_idx = 0; prev_acc = 0;
    bus0.rsp_ready = 1'b1;
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      idx = $urandom_range(0, D0 - 1);
      if (prev_rbw) idx = prev_idx;
      a = BASE + 64'd4 * 64'(idx);
      if (!prev_rbw && i % 5 == 4) a = a + 64'd4 * 64'(D0);
      if (!prev_rbw && i % 7 == 6) a = a + 64'd2;
      model0(a, w, e);
      rbw = (i % 3 == 1) && !e;
      k = 0;
      while (!bus0.req_ready && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      bus0.req_addr = a;
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (i > 0) begin
        n_checks++;
        if (acc_cyc - prev_acc !== 3)
          $display("FAIL lat0_throughput[%0d]: got %0d cycles expected 3", i, acc_cyc - prev_acc);
        else n_pass++;
      end
      prev_acc = acc_cyc;
      bus0.req_addr = {$urandom, $urandom};
      nw = $urandom;
      if (rbw) begin
        ld_en0 = 1'b1; ld_idx0 = 4'(idx); ld_data0 = nw;
      end
      @(posedge clk); #1;
      ld_en0 = 1'b0;
      if (rbw) ref0[idx] = nw;
      n_checks++;
      if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_instr} !== {1'b1, e, w})
        $display("FAIL lat0_fetch[%0d]: got valid=%b err=%b instr=%h expected 1/%b/%h",
                 i, bus0.rsp_valid, bus0.rsp_err, bus0.rsp_instr, e, w);
      else n_pass++;
      prev_rbw = rbw;
      prev_idx = idx;
    end
    bus0.req_valid = 1'b0;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL lat0_drain: got valid=%b busy=%b expected 0/0", bus0.rsp_valid, busy0);
    else n_pass++;
  endtask

  initial begin
    bus2.req_valid = 1'b0; bus2.req_addr = 64'h0; bus2.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_addr = 64'h0; bus0.rsp_ready = 1'b0;
    test_reset;
    test_preload;
    test_basic_fetch;
    test_backpressure;
    test_errors;
    test_last_word;
    test_random;
    test_reset_mid_wait;
    test_lat0_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
